// File: rtl/csi_rx_dly_cal.sv
// csi_rx_dly_cal: per-lane input-delay calibration for the CSI-2 RX PHY.
// Sweeps each lane's tap, grades it by packet results, centres the best run.
module csi_rx_dly_cal #(
    parameter int NUM_LANE = 2,
    parameter int TAP_W = 5,
    parameter int SETTLE_CYC = 64,
    parameter int WIN_CYC = 65536,
    parameter int MIN_OK = 4,
    parameter logic [NUM_LANE*TAP_W-1:0] DEFAULT_DLY = 10'h063,
    localparam int LANE_W = (NUM_LANE > 1) ? $clog2(NUM_LANE) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      start,
    input  logic                      pkt_ok,
    input  logic                      pkt_err,
    output logic [NUM_LANE*TAP_W-1:0] delay,
    output logic                      busy,
    output logic                      locked,
    output logic [NUM_LANE-1:0]       cal_fail,
    output logic [LANE_W-1:0]         lane_idx
);

    localparam logic [TAP_W-1:0] TAP_MAX = '1;
    localparam int CNT_W = $clog2(SETTLE_CYC + WIN_CYC + 1);
    localparam int OK_W = $clog2(MIN_OK + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WIN_CYC - 1);
    localparam logic [OK_W-1:0] OK_MAX = OK_W'(MIN_OK);
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(NUM_LANE - 1);

    typedef enum logic [2:0] {
        IDLE,
        SET,
        SETTLE,
        MEASURE,
        EVAL,
        NEXT_LANE,
        DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [TAP_W-1:0] tap;
    logic [OK_W-1:0]  ok_cnt;
    logic             err_flag;
    logic [TAP_W-1:0] run_start;
    logic [TAP_W:0]   run_len;
    logic [TAP_W-1:0] best_start;
    logic [TAP_W:0]   best_len;

    logic             pass;
    logic             close_run;
    logic [TAP_W-1:0] cand_start;
    logic [TAP_W:0]   cand_len;
    logic [TAP_W-1:0] centre;
    logic [TAP_W-1:0] dflt_tap;

    // Grade the finished window and form the run that would close here.
    always_comb begin
        pass       = (ok_cnt == OK_MAX) && !err_flag;
        close_run  = !pass || (tap == TAP_MAX);
        cand_start = (pass && run_len == '0) ? tap : run_start;
        cand_len   = pass ? run_len + 1'b1 : run_len;
        // Run never exceeds TAP_MAX+1 taps, so the centre fits in TAP_W bits.
        centre     = best_start + TAP_W'((best_len - 1'b1) >> 1);
        dflt_tap   = DEFAULT_DLY[lane_idx*TAP_W +: TAP_W];
    end

    // Calibration sequencer with registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            tap        <= '0;
            ok_cnt     <= '0;
            err_flag   <= 1'b0;
            run_start  <= '0;
            run_len    <= '0;
            best_start <= '0;
            best_len   <= '0;
            delay      <= DEFAULT_DLY;
            busy       <= 1'b0;
            locked     <= 1'b0;
            cal_fail   <= '0;
            lane_idx   <= '0;
        end else if (state != IDLE && !enable) begin
            state  <= IDLE;
            busy   <= 1'b0;
            locked <= 1'b0;
            if (state != DONE) begin
                delay[lane_idx*TAP_W +: TAP_W] <= dflt_tap;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (start && enable) begin
                        state      <= SET;
                        busy       <= 1'b1;
                        locked     <= 1'b0;
                        cal_fail   <= '0;
                        lane_idx   <= '0;
                        tap        <= '0;
                        run_start  <= '0;
                        run_len    <= '0;
                        best_start <= '0;
                        best_len   <= '0;
                    end
                end
                SET: begin
                    delay[lane_idx*TAP_W +: TAP_W] <= tap;
                    cnt      <= '0;
                    ok_cnt   <= '0;
                    err_flag <= 1'b0;
                    state    <= SETTLE;
                end
                SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        cnt   <= '0;
                        state <= MEASURE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                MEASURE: begin
                    if (pkt_ok && ok_cnt != OK_MAX) begin
                        ok_cnt <= ok_cnt + 1'b1;
                    end
                    if (pkt_err) begin
                        err_flag <= 1'b1;
                    end
                    if (cnt == WIN_LAST) begin
                        cnt   <= '0;
                        state <= EVAL;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                EVAL: begin
                    if (close_run) begin
                        if (cand_len > best_len) begin
                            best_start <= cand_start;
                            best_len   <= cand_len;
                        end
                        run_len <= '0;
                    end else begin
                        run_start <= cand_start;
                        run_len   <= cand_len;
                    end
                    if (tap != TAP_MAX) begin
                        tap   <= tap + 1'b1;
                        state <= SET;
                    end else begin
                        state <= NEXT_LANE;
                    end
                end
                NEXT_LANE: begin
                    if (best_len != '0) begin
                        delay[lane_idx*TAP_W +: TAP_W] <= centre;
                    end else begin
                        delay[lane_idx*TAP_W +: TAP_W] <= dflt_tap;
                        cal_fail[lane_idx] <= 1'b1;
                    end
                    run_start  <= '0;
                    run_len    <= '0;
                    best_start <= '0;
                    best_len   <= '0;
                    if (lane_idx != LANE_LAST) begin
                        lane_idx <= lane_idx + 1'b1;
                        tap      <= '0;
                        state    <= SET;
                    end else begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    busy   <= 1'b0;
                    locked <= ~|cal_fail;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/csi_rx_dly_cal.md
Name: csi_rx_dly_cal

Overview:
- Per-lane input-delay calibration controller for the CSI-2 RX data PHY lanes.
- Sequences each lane's 5-bit delay tap through 0..TAP_MAX and grades each tap by packet-handler results (good / bad packet pulses).
- Selects the centre of the longest contiguous passing tap run and holds it on the delay bus that drives the lane PHYs.
- Sits in the byte-clock domain beside the packet handler and replaces the free-running delay sweep.

Parameters:
- NUM_LANE, 2, number of data lanes calibrated.
- TAP_W, 5, delay tap width per lane; TAP_MAX = 2^TAP_W-1.
- SETTLE_CYC, 64, cycles waited after a tap change before measuring (>=1).
- WIN_CYC, 65536, measurement window length in cycles (>=1).
- MIN_OK, 4, good packets required in a window for a tap to pass (>=1).
- DEFAULT_DLY, 10'h063, per-lane fallback taps, lane i at [i*TAP_W +: TAP_W].

Ports:
- clock  in  1  byte clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high.
- enable  in  1  camera enable; low aborts calibration.
- start  in  1  single-cycle request to (re)calibrate; sampled only in IDLE.
- pkt_ok  in  1  pulse: packet completed with valid header/ECC.
- pkt_err  in  1  pulse: packet header/ECC error or sync loss.
- delay  out  NUM_LANE*TAP_W  tap value per lane to the PHY delay inputs.
- busy  out  1  calibration in progress.
- locked  out  1  all lanes calibrated with a passing run.
- cal_fail  out  NUM_LANE  per-lane: no passing tap found; lane uses default.
- lane_idx  out  clog2(NUM_LANE) (min 1)  lane currently under test.

Behaviour:
- Reset: delay=DEFAULT_DLY, busy=0, locked=0, cal_fail=0, lane_idx=0, state IDLE. All outputs are registered.
- States: IDLE -> SET -> SETTLE -> MEASURE -> EVAL -> (SET next tap | NEXT_LANE) -> ... -> DONE -> IDLE.
- IDLE: when start=1 and enable=1, go to SET. Set busy=1, locked=0, cal_fail=0, lane_idx=0, tap=0. Clear run trackers.
- SET (1 cycle): drive tap onto delay[lane_idx]. Other lanes hold their current value (calibrated result or default).
- SETTLE: exactly SETTLE_CYC cycles. Packet pulses are ignored.
- MEASURE: exactly WIN_CYC cycles. ok_cnt counts pkt_ok and saturates at MIN_OK. err_flag sets on any pkt_err. If both pulse in the same cycle, both are recorded.
- EVAL (1 cycle), pulses ignored:
  - pass = (ok_cnt==MIN_OK) && !err_flag.
  - On pass: if the current run is empty, run_start=tap; run_len+=1.
  - On fail, or on the last tap while passing: if run_len > best_len (strictly greater, so the first-found run wins ties), set best_start=run_start and best_len=run_len; then clear the run.
  - The run ending at TAP_MAX must be closed before selection.
  - If tap<TAP_MAX: tap+=1, go to SET. Otherwise go to NEXT_LANE.
- Per-tap cost: SETTLE_CYC + WIN_CYC + 2 cycles.
- NEXT_LANE (1 cycle):
  - If best_len>0: delay[lane] = best_start + ((best_len-1)>>1), computed at TAP_W+1 bits (result is always <= TAP_MAX).
  - Else: delay[lane] = DEFAULT_DLY lane slice and cal_fail[lane]=1.
  - Clear trackers. If lane_idx<NUM_LANE-1: lane_idx+=1, tap=0, go to SET. Otherwise go to DONE.
- DONE (1 cycle): busy=0, locked = ~|cal_fail, go to IDLE.
- Abort: enable=0 in any non-IDLE state -> next cycle IDLE, busy=0, locked=0. The lane under test reverts to its default slice. Lanes already finished keep their result; their cal_fail bits are kept.
- start while busy is ignored.
- enable=0 in IDLE leaves delay and locked unchanged.

Test Plan (SETTLE_CYC=4, WIN_CYC=16, MIN_OK=2, per-tap 22 cycles):
- Single pass run: lane0 taps 8..14 pass (2 pkt_ok each window), lane1 taps 20..27 pass, all others silent; start at cycle 0 -> busy=1 from cycle 1; delay={5'd23,5'd11}, locked=1, busy=0 at cycle 1+2*32*22+NUM_LANE (NEXT_LANE cycles) +1; cal_fail=0.
- Two runs and a tie: lane0 passes 3..6 and 20..27 -> tap 23 chosen. Lane0 passes 2..5 and 10..13 (equal length) -> tap 3 (first run wins).
- Run reaching the top tap: lane0 passes 28..31 -> tap 29.
- Error pulse: lane1 taps 20..27 give 2 pkt_ok, but tap 24 also sees pkt_err -> runs 20..23 and 25..27 -> tap 21.
- No pass: lane1 gets no pkt_ok -> delay[9:5]=5'h03, cal_fail=2'b10, locked=0.
- Abort and recovery:
  - Deassert enable during lane1 MEASURE -> next cycle busy=0, locked=0, delay[9:5]=5'h03, lane0 keeps its result.
  - start pulsed while busy -> no effect.
  - Assert reset mid-SETTLE -> all outputs return to reset values immediately.
